// File: rtl/nibble_block_packer_if.sv
// Bus bundle between the nibble packer, the receive/transmit RAMs and the cipher core.
// master = packer side, slave = RAM/cipher side.
interface nibble_block_packer_if #(
  parameter int RAM_BLOCKS = 8
);
  localparam int SW = $clog2(RAM_BLOCKS);

  logic          istart;
  logic [SW-1:0] osel_ram;
  logic [9:0]    oraddr;
  logic [3:0]    irdata;
  logic [9:0]    owaddr;
  logic [3:0]    owdata;
  logic          owrite_en;
  logic [63:0]   oblock;
  logic          oblock_valid;
  logic [63:0]   iblock;
  logic          iblock_valid;
  logic          obusy;
  logic          odone;

  modport master (
    input  istart, irdata, iblock, iblock_valid,
    output osel_ram, oraddr, owaddr, owdata, owrite_en,
           oblock, oblock_valid, obusy, odone
  );

  modport slave (
    output istart, irdata, iblock, iblock_valid,
    input  osel_ram, oraddr, owaddr, owdata, owrite_en,
           oblock, oblock_valid, obusy, odone
  );
endinterface

// File: rtl/nibble_block_packer.sv
// Reads every receive-RAM block as 4-bit nibbles, packs 16 into a 64-bit word for the
// cipher, and writes the result back nibble-by-nibble to the same transmit-RAM location.
module nibble_block_packer #(
  parameter int RAM_BLOCKS = 8
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  nibble_block_packer_if.master bus
);
  localparam int SW = $clog2(RAM_BLOCKS);
  localparam logic [SW-1:0] BLK_LAST = SW'(RAM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CIPHER, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [5:0]    word;
  logic [4:0]    nib;
  logic [SW-1:0] blk;
  logic [9:0]    raddr, waddr;
  logic [3:0]    wdata;
  logic          wen, pvld, busy, done;
  logic [63:0]   pack, unpack;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state  <= S_IDLE;
      word   <= '0;
      nib    <= '0;
      blk    <= '0;
      raddr  <= '0;
      waddr  <= '0;
      wdata  <= '0;
      wen    <= 1'b0;
      pvld   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pack   <= '0;
      unpack <= '0;
    end else begin
      pvld <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.istart) begin
            state <= S_LOAD;
            word  <= '0;
            blk   <= '0;
            nib   <= '0;
            raddr <= '0;
            busy  <= 1'b1;
          end
        end
        // RAM data lags the address by one cycle, so shifting runs on nib 1..16
        S_LOAD: begin
          if (nib != 5'd0) pack <= {pack[59:0], bus.irdata};
          if (nib < 5'd15) raddr <= {word, nib[3:0] + 4'd1};
          if (nib == 5'd16) begin
            state <= S_CIPHER;
            pvld  <= 1'b1;
          end else begin
            nib <= nib + 5'd1;
          end
        end
        S_CIPHER: begin
          if (bus.iblock_valid) begin
            wdata  <= bus.iblock[63:60];
            unpack <= {bus.iblock[59:0], 4'h0};
            waddr  <= {word, 4'h0};
            wen    <= 1'b1;
            nib    <= '0;
            state  <= S_STORE;
          end
        end
        S_STORE: begin
          if (nib == 5'd15) begin
            wen   <= 1'b0;
            state <= S_NEXT;
          end else begin
            nib    <= nib + 5'd1;
            waddr  <= {word, nib[3:0] + 4'd1};
            wdata  <= unpack[63:60];
            unpack <= {unpack[59:0], 4'h0};
          end
        end
        // Block select moves only here, so the new block is first seen by the next LOAD
        S_NEXT: begin
          nib <= '0;
          if (word != 6'd63) begin
            word  <= word + 6'd1;
            raddr <= {word + 6'd1, 4'h0};
            state <= S_LOAD;
          end else if (blk != BLK_LAST) begin
            blk   <= blk + SW'(1);
            word  <= '0;
            raddr <= '0;
            state <= S_LOAD;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          blk   <= '0;
          word  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.osel_ram     = blk;
  assign bus.oraddr       = raddr;
  assign bus.owaddr       = waddr;
  assign bus.owdata       = wdata;
  assign bus.owrite_en    = wen;
  assign bus.oblock       = pack;
  assign bus.oblock_valid = pvld;
  assign bus.obusy        = busy;
  assign bus.odone        = done;
endmodule

// File: tb/tb_nibble_block_packer.sv
// Scoreboard bench: RAM + cipher models drive the packer; expected words and writes are
// queued from a reference model and popped by an independent monitor.
module tb_nibble_block_packer;
  localparam int NB    = 2;
  localparam int SW    = $clog2(NB);
  localparam int WORDS = 64 * NB;

  logic iclk = 1'b0;
  logic irst_n = 1'b0;

  nibble_block_packer_if #(.RAM_BLOCKS(NB)) bus ();
  nibble_block_packer #(.RAM_BLOCKS(NB)) dut (.iclk(iclk), .irst_n(irst_n), .bus(bus));

  always #5 iclk = ~iclk;

  logic [3:0]      rx  [NB][1024];
  logic [3:0]      tx  [NB][1024];
  logic [3:0]      tx0 [NB][1024];
  logic [SW+13:0]  wq[$];
  logic [63:0]     bq[$];

  int errors = 0, checks = 0;
  int cyc = 0;
  int lat = 3, mode = 0;
  bit spur_arm = 0, mon_en = 0;
  int done_tot = 0, vld_tot = 0, done_cyc = 0;
  bit first_seen = 0;
  logic [63:0] first_oblock = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cipher(input logic [63:0] x);
    return (mode == 1) ? (x ^ 64'hFFFF0000FFFF0000) : x;
  endfunction

  initial forever @(posedge iclk) cyc = cyc + 1;

  // RAM (1-cycle read latency) and cipher (latency lat) models
  initial begin
    logic [9:0]    ra_q;
    logic [SW-1:0] rs_q;
    logic [63:0]   held;
    bit            pend, spur_used;
    int            cnt;
    ra_q = '0; rs_q = '0; held = '0; pend = 0; spur_used = 0; cnt = 0;
    bus.irdata = '0; bus.iblock = '0; bus.iblock_valid = 1'b0;
    forever @(negedge iclk) begin
      bus.iblock_valid = 1'b0;
      if (!irst_n) begin
        pend = 0;
      end else begin
        bus.irdata = rx[rs_q][ra_q];
        ra_q = bus.oraddr;
        rs_q = bus.osel_ram;
        if (bus.oblock_valid) begin pend = 1; cnt = lat; held = bus.oblock; end
        if (pend) begin
          if (cnt == 0) begin
            bus.iblock = cipher(held); bus.iblock_valid = 1'b1; pend = 0;
          end else cnt--;
        end
        if (!spur_arm) spur_used = 0;
        else if (!spur_used && bus.owrite_en && bus.owaddr[3:0] == 4'd7) begin
          bus.iblock = {$urandom, $urandom}; bus.iblock_valid = 1'b1; spur_used = 1;
        end
      end
    end
  end

  // Monitor: pops scoreboard on every write strobe and cipher request
  initial forever @(negedge iclk) begin
    if (mon_en && irst_n) begin
      if (bus.owrite_en) begin
        tx[bus.osel_ram][bus.owaddr] = bus.owdata;
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: got blk %0d addr %0d data %0h, expected no write",
                   bus.osel_ram, bus.owaddr, bus.owdata);
        end else chk("write", {bus.osel_ram, bus.owaddr, bus.owdata}, wq.pop_front());
      end
      if (bus.oblock_valid) begin
        vld_tot++;
        if (!first_seen) begin first_seen = 1; first_oblock = bus.oblock; end
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_oblock: got %0h expected no request", bus.oblock);
        end else chk("oblock", bus.oblock, bq.pop_front());
      end
      if (bus.odone) begin done_tot++; done_cyc = cyc; end
    end
  end

  task automatic fill_random();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++) rx[b][a] = 4'($urandom);
  endtask

  task automatic build_expect();
    logic [63:0] w, o;
    wq.delete(); bq.delete();
    for (int b = 0; b < NB; b++)
      for (int wi = 0; wi < 64; wi++) begin
        w = '0;
        for (int i = 0; i < 16; i++) w = {w[59:0], rx[b][wi*16+i]};
        bq.push_back(w);
        o = cipher(w);
        for (int i = 0; i < 16; i++)
          wq.push_back({SW'(b), 10'(wi*16+i), o[63-4*i -: 4]});
      end
  endtask

  task automatic start_pulse(output int st);
    @(negedge iclk);
    bus.istart = 1'b1; st = cyc;
    @(negedge iclk);
    bus.istart = 1'b0;
    chk("start_state", {bus.obusy, bus.osel_ram, bus.oraddr}, {1'b1, SW'(0), 10'd0});
  endtask

  task automatic run(input int l, input int m, input bit re_start, input bit spur);
    int st, d0, v0;
    bit pulsed;
    lat = l; mode = m; pulsed = 0;
    build_expect();
    d0 = done_tot; v0 = vld_tot;
    mon_en = 1;
    start_pulse(st);
    spur_arm = spur;
    for (int i = 0; i < 30000 && done_tot == d0; i++) begin
      @(negedge iclk);
      if (re_start && !pulsed && bus.osel_ram == SW'(1) && bus.oraddr == 10'd5) begin
        bus.istart = 1'b1; @(negedge iclk); bus.istart = 1'b0; pulsed = 1;
      end
    end
    chk("done_seen", 64'(done_tot != d0), 64'd1);
    repeat (6) @(negedge iclk);
    spur_arm = 0;
    mon_en = 0;
    chk("done_count", done_tot - d0, 1);
    chk("oblock_valid_count", vld_tot - v0, WORDS);
    chk("writes_left", wq.size(), 0);
    chk("words_left", bq.size(), 0);
    chk("busy_after", bus.obusy, 0);
    chk("cycles", done_cyc - st, WORDS * (35 + l) + 1);
  endtask

  function automatic int diff_tx_rx();
    int n = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++) if (tx[b][a] !== rx[b][a]) n++;
    return n;
  endfunction

  initial begin
    int n;
    bit hit;
    bus.istart = 1'b0;
    irst_n = 1'b0;
    repeat (3) @(negedge iclk);
    chk("reset_ctrl", {bus.osel_ram, bus.oraddr, bus.owaddr, bus.owdata, bus.owrite_en,
                       bus.oblock_valid, bus.obusy, bus.odone}, '0);
    chk("reset_oblock", bus.oblock, 64'd0);
    irst_n = 1'b1;

    // identity cipher, RAM holds address[3:0]
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++) rx[b][a] = 4'(a);
    run(3, 0, 0, 0);
    chk("first_oblock", first_oblock, 64'h0123456789ABCDEF);
    chk("identity_copy", diff_tx_rx(), 0);

    // XOR cipher
    fill_random();
    run(3, 1, 0, 0);

    // latency 0 vs latency 20 on the same data
    fill_random();
    run(0, 0, 0, 0);
    tx0 = tx;
    run(20, 0, 0, 0);
    n = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++) if (tx[b][a] !== tx0[b][a]) n++;
    chk("lat0_vs_lat20", n, 0);
    chk("lat20_identity", diff_tx_rx(), 0);

    // istart while busy and spurious cipher result in STORE
    fill_random();
    run(3, 1, 1, 1);

    // reset during STORE of word 10
    fill_random();
    lat = 3; mode = 0;
    build_expect();
    mon_en = 1;
    begin
      int st;
      start_pulse(st);
    end
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge iclk);
      if (bus.owrite_en && bus.owaddr == 10'd164) hit = 1;
    end
    chk("reach_word10", 64'(hit), 64'd1);
    mon_en = 0;
    irst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {bus.osel_ram, bus.oraddr, bus.owaddr, bus.owdata, bus.owrite_en,
                        bus.oblock_valid, bus.obusy, bus.odone}, '0);
    chk("midrst_oblock", bus.oblock, 64'd0);
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;
    run(3, 0, 0, 0);
    chk("restart_identity", diff_tx_rx(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_block_packer.md
Name: nibble_block_packer

Overview:
- Data-processing stage between the D-line driver's receive RAM and its transmit RAM.
- Once the driver has filled every RAM block, the packer reads the 4-bit RAM contents, packs 16 nibbles into 64-bit words and hands each word to the GOST cipher core.
- Each 64-bit result is unpacked back into 16 nibbles and written to the transmit RAM at the same block and address.
- A done pulse releases the D-line driver to start sending.

Parameters:
RAM_BLOCKS, 8, number of 512-byte RAM blocks (1024 nibbles each); power of two, ≥2.

Ports:
iclk  in  1  SD clock
irst_n  in  1  asynchronous active-low reset
istart  in  1  start pulse (driver has finished receiving); ignored unless IDLE
osel_ram  out  $clog2(RAM_BLOCKS)  RAM block select, shared by the read and write RAMs
oraddr  out  10  read nibble address, receive RAM
irdata  in  4  receive RAM read data, 1-cycle latency after oraddr
owaddr  out  10  write nibble address, transmit RAM
owdata  out  4  transmit RAM write data
owrite_en  out  1  transmit RAM write strobe
oblock  out  64  word to cipher
oblock_valid  out  1  1-cycle request pulse to cipher
iblock  in  64  cipher result
iblock_valid  in  1  cipher result valid, 1-cycle pulse
obusy  out  1  high whenever state != IDLE
odone  out  1  1-cycle pulse after the last nibble of the last block is written

Behaviour:
- Reset (async, irst_n=0): state IDLE; all counters zero; osel_ram=0; oraddr=owaddr=0; oblock=0; owdata=0; owrite_en=0; oblock_valid=0; obusy=0; odone=0.
- Reset asserted mid-operation aborts immediately. No partial-word completion.
- Internal counters: word (6 bit, 0..63, within the block); nib (5 bit); blk (= osel_ram).
- IDLE: on istart, go to LOAD with word=0, blk=0, nib=0.
- LOAD: lasts 17 cycles, nib = 0..16.
  - For nib 0..15: oraddr = {word, nib[3:0]}.
  - For nib 1..16: shift irdata into the pack register, oblock <= {oblock[59:0], irdata}. The first nibble read ends in bits [63:60] (MSB-first, matching SD bus order).
  - After nib=16, go to CIPHER.
- CIPHER:
  - oblock_valid is high for exactly the first cycle in the state. oblock is stable for the whole state.
  - Wait for iblock_valid. A result in the same cycle as oblock_valid is legal, but cipher latency ≥1 is expected.
  - On iblock_valid: latch iblock into the unpack register and go to STORE with nib=0.
  - iblock_valid outside CIPHER is ignored.
- STORE: lasts 16 cycles, nib = 0..15.
  - owrite_en=1; owaddr = {word, nib[3:0]}; owdata = unpack[63:60], then shift left 4 each cycle.
  - After nib=15, go to NEXT.
- NEXT (1 cycle):
  - word≠63: word+1 → LOAD.
  - word=63 and blk≠RAM_BLOCKS-1: blk+1, word=0 → LOAD.
  - word=63 and blk=RAM_BLOCKS-1: go to DONE.
- DONE (1 cycle): odone=1; blk and word cleared → IDLE.
- istart while obusy: ignored, no restart.
- Throughput per 64-bit word: 17 (LOAD) + L+1 (CIPHER, L = cipher latency) + 16 (STORE) + 1 (NEXT) cycles.
- owrite_en is never high outside STORE. oraddr holds its last value outside LOAD.
- osel_ram changes only in NEXT/DONE, never while a read or write is in flight.
- Address arithmetic wraps naturally within 10 bits; word=63, nib=15 gives address 1023.

Test Plan:
- Identity cipher (iblock=oblock, L=3), RAM_BLOCKS=2, receive RAM filled with address[3:0] → transmit RAM equals receive RAM. First oblock = 64'h0123456789ABCDEF. odone pulses once, after exactly 128 words. Total cycles from istart to odone = 128×(17+4+16+1)+1.
- XOR cipher model (iblock = oblock ^ 64'hFFFF0000FFFF0000) → nibbles 0–3 of each word inverted, nibbles 4–7 unchanged, nibbles 8–11 inverted, nibbles 12–15 unchanged; owaddr sequence 0..1023 per block.
- Cipher latency 0 (iblock_valid coincident with oblock_valid) and latency 20 → identical RAM contents; oblock_valid count = 64×RAM_BLOCKS.
- istart pulsed again mid-LOAD of block 1 and spurious iblock_valid in STORE → no restart, no extra writes, single odone.
- irst_n low during STORE of word 10 → all outputs 0 in the same cycle. A new istart after release restarts at blk=0, word=0, oraddr=0.
- Boundary check: last word of block 0 → osel_ram steps 0→1 in NEXT. The next oraddr is 0. No write occurs with the new osel_ram before the new LOAD.
